clz_norm_seq: RTL and testbench
===============================

# clz_norm_seq

Sequenced 32-bit leading-zero count and normalize unit built around a single shared `clz_16` instance. It accepts a 32-bit mantissa over a valid/ready handshake. It counts leading zeros by time-multiplexing the one `clz_16` over the upper half, then the lower half only when the upper half is zero. It then left-shifts the operand so bit 31 is set and returns the result with its count over a second valid/ready handshake. It sits in front of the FPU normalization/rounding stage, where area matters more than throughput.

## Interface
- Parameters: none (width fixed at 32; count width fixed at 6).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand (IDLE only).
- in_data  input  32  operand to normalize.
- out_valid  output  1  result held on out_*.
- out_ready  input  1  consumer accepts result.
- out_data  output  32  in_data << out_count (0 when operand is zero).
- out_count  output  6  leading-zero count, 0..32.
- out_zero  output  1  operand was all zeros (out_count == 32).
- busy  output  1  state != IDLE.

## Operation
- Exactly one `clz_16` instance. Its input is a mux of operand[31:16] (state HI) and operand[15:0] (state LO); any other state drives 16'h0000.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid && in_ready, latch in_data into the operand register and go to HI.
  - HI:
    - clz_16 sees operand[31:16]; result c_hi (0..16).
    - If c_hi < 16: cnt <= c_hi, go to SHIFT.
    - Else: go to LO.
  - LO:
    - clz_16 sees operand[15:0]; result c_lo.
    - cnt <= 16 + c_lo (16..32); go to SHIFT.
  - SHIFT:
    - out_data <= (cnt == 32) ? 0 : operand << cnt[4:0].
    - out_count <= cnt; out_zero <= (cnt == 32); go to DONE.
  - DONE:
    - out_valid=1; out_data, out_count and out_zero are held stable.
    - On out_ready, go to IDLE.
- in_ready is a decode of state == IDLE. No operand is accepted in DONE, even when out_ready is high in the same cycle. No bypass, one operation in flight.
- Width rules:
  - cnt is 6 bits; 16 + c_lo uses a zero-extended 6-bit add and never overflows.
  - The shift is a logical left shift with zero fill.
  - out_data[31]=1 for every nonzero operand.
- in_data changes after acceptance have no effect; the operand register is the only source.
- out_ready while not in DONE is ignored.

## Timing
- Acceptance cycle T (in_valid && in_ready sampled high at the edge).
- Upper half nonzero: HI at T+1, SHIFT at T+2, out_valid=1 from T+3.
- Upper half zero: HI at T+1, LO at T+2, SHIFT at T+3, out_valid=1 from T+4.
- out_valid stays high until the edge where out_ready=1. The block is in IDLE (in_ready=1) the following cycle.
- Minimum initiation interval is 4 cycles (upper half nonzero, out_ready held high), or 5 cycles (upper half zero).
- Reset:
  - reset high at an edge forces IDLE and clears the operand, cnt, out_data, out_count and out_zero to 0.
  - in_ready=0 and out_valid=0 while reset is asserted. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation (HI/LO/SHIFT/DONE) abandons the operation; no out_valid is produced for it.
- in_valid during reset is not accepted.

## Test plan
- Reset then idle:
  - reset high for 2 cycles -> out_valid=0, out_count=0, out_data=0, in_ready=0 during reset.
  - in_ready=1 the cycle after deassert.
- Upper-half path: in_data=32'h0001_2345, out_ready=1 -> out_valid at T+3, out_count=15, out_data=32'h91A2_8000, out_zero=0.
- Lower-half path: in_data=32'h0000_0001 -> out_valid at T+4, out_count=31, out_data=32'h8000_0000.
- Zero and already-normalized operands:
  - in_data=0 -> T+4, out_count=32, out_zero=1, out_data=0.
  - in_data=32'h8000_0000 -> T+3, out_count=0, out_data unchanged.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 and new in_data -> out_* stable, in_ready=0, second operand not accepted.
  - Raise out_ready -> next cycle IDLE, second operand accepted.
- Reset mid-operation:
  - Assert reset in the LO state of in_data=32'h0000_00F0 -> no out_valid, outputs 0.
  - After release, in_data=32'h0000_00F0 -> out_count=24, out_data=32'hF000_0000.

Source files
------------

// File: rtl/clz_norm_seq.sv
// clz_norm_seq: sequenced 32-bit leading-zero count and normalize unit.
//
// One shared clz_16 is time-multiplexed over the upper half of the latched
// operand and, only when that half is all zeros, over the lower half. The
// operand is then left-shifted so that bit 31 is set. The result is returned
// together with its leading-zero count.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. The producer holds valid and data until that
// edge. in_ready is high only in IDLE. out_valid is high only in DONE, and
// out_* stay stable for as long as it is high.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake, in_data[31:0] operand
//   out_valid/out_ready result handshake
//   out_data[31:0]      normalized operand (0 for a zero operand)
//   out_count[5:0]      leading-zero count, 0..32
//   out_zero            operand was zero (out_count == 32)
//   busy                FSM is not in IDLE (observable state indicator)

module clz_16 (
  input  logic [15:0] data,
  output logic [4:0]  count
);
  // The highest set bit is visited last and wins. A zero input gives 16.
  always_comb begin
    count = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (data[i]) count = 5'(15 - i);
    end
  end
endmodule

module clz_norm_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_count,
  output logic        out_zero,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] operand;
  logic [5:0]  cnt;
  logic [15:0] clz_in;
  logic [4:0]  clz_cnt;

  // The single shared counter, fed by a state-selected half of the operand.
  always_comb begin
    clz_in = 16'h0000;
    case (state)
      S_HI:    clz_in = operand[31:16];
      S_LO:    clz_in = operand[15:0];
      default: clz_in = 16'h0000;
    endcase
  end

  clz_16 u_clz (
    .data  (clz_in),
    .count (clz_cnt)
  );

  // Next-state logic. Bit 4 of the clz result is set only for a count of 16,
  // which means the upper half is all zeros.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = S_HI;
      S_HI:    state_next = clz_cnt[4] ? S_LO : S_SHIFT;
      S_LO:    state_next = S_SHIFT;
      S_SHIFT: state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      operand   <= 32'h0;
      cnt       <= 6'd0;
      out_data  <= 32'h0;
      out_count <= 6'd0;
      out_zero  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (in_valid) operand <= in_data;
        S_HI:   if (!clz_cnt[4]) cnt <= {1'b0, clz_cnt};
        S_LO:   cnt <= 6'd16 + {1'b0, clz_cnt};
        S_SHIFT: begin
          // A shift by 32 does not fit cnt[4:0], so the zero case is explicit.
          out_data  <= (cnt == 6'd32) ? 32'h0 : (operand << cnt[4:0]);
          out_count <= cnt;
          out_zero  <= (cnt == 6'd32);
        end
        default: ;
      endcase
    end
  end

  // Both handshake outputs are gated by reset so that they read low while
  // reset is held, even before the first edge has been sampled.
  assign in_ready  = (state == S_IDLE) && !reset;
  assign out_valid = (state == S_DONE) && !reset;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_clz_norm_seq.sv
// Directed testbench for clz_norm_seq. All expected values are hand-computed.
module tb_clz_norm_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_count;
  logic        out_zero;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  clz_norm_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  // ---------------- driver ----------------
  // Offers one operand while idle and returns the number of negedges from
  // acceptance until out_valid is first seen. That count is 3 when the upper
  // half is nonzero and 4 when it is zero, or -1 on timeout. The task also
  // returns the result captured at that point. out_ready is held high, so the
  // DUT is back in IDLE when the task returns.
  task automatic do_op(input logic [31:0] d, output int lat,
                       output logic [31:0] od, output logic [5:0] oc,
                       output logic oz);
    lat = -1; od = 'x; oc = 'x; oz = 'x;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;  // later changes must not disturb the result
    for (int k = 1; k <= 12; k++) begin
      if (out_valid) begin
        lat = k; od = out_data; oc = out_count; oz = out_zero;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
      end
      checks++;
      if (out_count !== 6'd0 || out_data !== 32'h0 || out_zero !== 1'b0) begin
        errors++; $display("FAIL reset_out: count=%0d data=%h zero=%b want 0/0/0", out_count, out_data, out_zero);
      end
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  // Runs one operand and compares all outputs against the given expectations.
  task automatic test_vector(input string nm, input logic [31:0] d,
                             input int exp_lat, input logic [5:0] exp_cnt,
                             input logic [31:0] exp_data);
    int lat; logic [31:0] od; logic [5:0] oc; logic oz;
    do_op(d, lat, od, oc, oz);
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, exp_lat);
    end
    checks++;
    if (oc !== exp_cnt) begin
      errors++; $display("FAIL %s_count: got %0d want %0d", nm, oc, exp_cnt);
    end
    checks++;
    if (od !== exp_data) begin
      errors++; $display("FAIL %s_data: got %h want %h", nm, od, exp_data);
    end
    checks++;
    if (oz !== (exp_cnt == 6'd32)) begin
      errors++; $display("FAIL %s_zero: got %b want %b", nm, oz, exp_cnt == 6'd32);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_return_idle: in_ready=%b out_valid=%b want 1/0", nm, in_ready, out_valid);
    end
  endtask

  task automatic test_upper();
    test_vector("upper",   32'h0001_2345, 3, 6'd15, 32'h91A2_8000);
    test_vector("upper16", 32'h0001_0000, 3, 6'd15, 32'h8000_0000);
    test_vector("ones",    32'hFFFF_FFFF, 3, 6'd0,  32'hFFFF_FFFF);
  endtask

  task automatic test_lower();
    test_vector("lower",   32'h0000_0001, 4, 6'd31, 32'h8000_0000);
    test_vector("lower15", 32'h0000_8000, 4, 6'd16, 32'h8000_0000);
    test_vector("lowerf0", 32'h0000_00F0, 4, 6'd24, 32'hF000_0000);
  endtask

  task automatic test_edges();
    test_vector("zero", 32'h0000_0000, 4, 6'd32, 32'h0000_0000);
    test_vector("norm", 32'h8000_0000, 3, 6'd0,  32'h8000_0000);
  endtask

  task automatic test_backpressure();
    int lat;
    lat = -1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0001_2345;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (out_valid) begin lat = k; break; end
      @(negedge clk);
    end
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL bp_latency: got %0d want 3", lat);
    end
    // Offer a second operand while the result is held.
    in_valid = 1'b1; in_data = 32'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h91A2_8000 ||
          out_count !== 6'd15 || out_zero !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b data=%h count=%0d want 1/0/91a28000/15",
                 i, out_valid, in_ready, out_data, out_count);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    // The second operand is still offered and is accepted on this edge.
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      if (out_valid) begin lat = k; break; end
      @(negedge clk);
    end
    checks++;
    if (lat !== 3 || out_count !== 6'd0 || out_data !== 32'h8000_0000) begin
      errors++; $display("FAIL bp_second: lat=%0d count=%0d data=%h want 3/0/80000000", lat, out_count, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h0000_00F0;
    @(negedge clk);           // HI
    in_valid = 1'b0;
    @(negedge clk);           // LO
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_pre: busy=%b out_valid=%b want 1/0", busy, out_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0 || out_count !== 6'd0) begin
      errors++; $display("FAIL mid_reset: valid=%b ready=%b data=%h count=%0d want 0/0/0/0",
                         out_valid, in_ready, out_data, out_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_abandon: out_valid cycles=%0d in_ready=%b want 0/1", seen, in_ready);
    end
    test_vector("after_reset", 32'h0000_00F0, 4, 6'd24, 32'hF000_0000);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0; reset = 1'b1;
    test_reset();
    test_upper();
    test_lower();
    test_edges();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
